// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver types, frame constants and parity helper
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} ps2_state_t;
  localparam int FRAME_BITS = 11;
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction
endpackage

// File: rtl/ps2_rx_channel.sv
// ps2_rx_channel: one PS/2 receive channel with sync, edge detect, FSM, timeout and inhibit
module ps2_rx_channel
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 32000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  output logic       clk_oe,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic clk_prev, fall, sd, par, par_n, valid_n, err_n;
  ps2_state_t state, state_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n, data_n;
  logic [TW-1:0] tcnt, tcnt_n;
  assign sd   = data_sync[SYNC_STAGES-1];
  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    data_n   = data;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    tcnt_n   = (state == IDLE || fall) ? '0 : tcnt + 1'b1;
    if (inhibit) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      tcnt_n   = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          err_n    = sd;
          state_n  = sd ? IDLE : SHIFT;
          bitcnt_n = '0;
        end
        SHIFT: begin
          shreg_n  = {sd, shreg[7:1]};
          bitcnt_n = bitcnt + 1'b1;
          state_n  = (bitcnt == 3'(FRAME_BITS - 4)) ? PARITY : SHIFT;
        end
        PARITY: begin
          par_n   = sd;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          valid_n = odd_parity_ok(shreg, par) && sd;
          err_n   = !valid_n;
          data_n  = valid_n ? shreg : data;
        end
      endcase
    end else if (state != IDLE && tcnt == TMAX) begin
      // stalled mid-frame: drop the partial byte
      state_n = IDLE;
      err_n   = 1'b1;
      tcnt_n  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      clk_oe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tcnt      <= tcnt_n;
      data      <= data_n;
      valid     <= valid_n;
      err       <= err_n;
      clk_oe    <= inhibit;
    end
  end
endmodule

// File: rtl/ps2_rx_multi.sv
// ps2_rx_multi: N-channel PS/2 receiver with most-recent-byte arbitration and debug nibble mux
module ps2_rx_multi #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 32000,
  parameter int DBG_W          = 4,
  localparam int CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ps2_clk,
  input  logic [NUM_CH-1:0]     ps2_data,
  input  logic [NUM_CH-1:0]     inhibit,
  output logic [NUM_CH-1:0]     ps2_clk_oe,
  output logic [NUM_CH*8-1:0]   rx_data,
  output logic [NUM_CH-1:0]     rx_valid,
  output logic [NUM_CH-1:0]     rx_err,
  output logic [7:0]            most_recent,
  output logic [CW-1:0]         most_recent_ch,
  input  logic [CW-1:0]         dbg_sel,
  input  logic                  dbg_hi,
  output logic [DBG_W-1:0]      dbg_out
);
  logic [7:0] rec_q;
  logic [CW-1:0] rec_ch_q;
  logic [3:0] nib;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ps2_rx_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk[i]),
      .ps2_data(ps2_data[i]),
      .inhibit(inhibit[i]),
      .clk_oe(ps2_clk_oe[i]),
      .data(rx_data[8*i +: 8]),
      .valid(rx_valid[i]),
      .err(rx_err[i])
    );
  end
  // scan downwards so the lowest strobing channel wins
  always_comb begin
    most_recent    = rec_q;
    most_recent_ch = rec_ch_q;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (rx_valid[i]) begin
        most_recent    = rx_data[8*i +: 8];
        most_recent_ch = CW'(i);
      end
  end
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (dbg_sel == CW'(i)) nib = dbg_hi ? rx_data[8*i+4 +: 4] : rx_data[8*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q    <= '0;
      rec_ch_q <= '0;
      dbg_out  <= '0;
    end else begin
      rec_q    <= most_recent;
      rec_ch_q <= most_recent_ch;
      dbg_out  <= DBG_W'(nib);
    end
  end
endmodule

// File: tb/tb_ps2_rx_multi.sv
// tb_ps2_rx_multi: directed PS/2 frames checked every cycle against a frame-level model
module tb_ps2_rx_multi;
  localparam int S = 2, T = 200, HALF = 10;
  logic clk = 0, rst = 1;
  logic [1:0] pc = 2'b11, pd = 2'b11, inhibit = 2'b00, oe, rx_valid, rx_err;
  logic [15:0] rx_data;
  logic [7:0] most_recent;
  logic most_recent_ch, dbg_sel = 0, dbg_hi = 0;
  logic [3:0] dbg_out;

  ps2_rx_multi #(.NUM_CH(2), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .DBG_W(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(pc), .ps2_data(pd), .inhibit(inhibit),
    .ps2_clk_oe(oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .most_recent(most_recent), .most_recent_ch(most_recent_ch),
    .dbg_sel(dbg_sel), .dbg_hi(dbg_hi), .dbg_out(dbg_out));

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, cyc = 0;
  logic rst_s = 0, sel_s = 0, hi_s = 0;
  logic [1:0] inh_s = 0;
  int ev_cyc[2] = '{-1, -1};
  logic ev_good[2] = '{0, 0};
  logic [7:0] ev_byte[2] = '{0, 0};
  logic [7:0] m_data[2] = '{0, 0};
  logic [7:0] m_rec = 0;
  logic m_ch = 0;
  int vcnt[2] = '{0, 0}, ecnt[2] = '{0, 0};
  logic [1:0] xv, xe;
  logic [3:0] xd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // odd parity bit makes the ones count over data+parity odd
  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, ~(^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: judge the frame at its last edge; 1: expect a timeout error; 2: aborted, no strobe
  task automatic send(input logic [1:0] mask, input logic [10:0] f0, input logic [10:0] f1,
                      input int nbits, input int mode);
    logic [10:0] f;
    for (int i = 0; i < nbits; i++) begin
      for (int ch = 0; ch < 2; ch++) if (mask[ch]) pd[ch] = (ch == 0) ? f0[i] : f1[i];
      wait_cyc(HALF);
      pc = pc & ~mask;
      if (i == nbits - 1)
        for (int ch = 0; ch < 2; ch++)
          if (mask[ch] && mode != 2) begin
            f = (ch == 0) ? f0 : f1;
            ev_cyc[ch]  = cyc + S + 1 + ((mode == 1) ? T : 0);
            ev_good[ch] = (mode == 0) && !f[0] && (^f[9:1]) && f[10];
            ev_byte[ch] = f[8:1];
          end
      wait_cyc(HALF);
      pc = pc | mask;
    end
    pd = pd | mask;
    wait_cyc(HALF);
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_s = rst;
    inh_s = inhibit;
    sel_s = dbg_sel;
    hi_s  = dbg_hi;
  end

  always @(negedge clk) if (cyc > 0) begin
    xd = rst_s ? 4'h0 : (hi_s ? m_data[sel_s][7:4] : m_data[sel_s][3:0]);
    xv = 0;
    xe = 0;
    if (rst_s) begin
      m_data = '{0, 0};
      m_rec  = 0;
      m_ch   = 0;
      ev_cyc = '{-1, -1};
    end
    for (int ch = 0; ch < 2; ch++)
      if (cyc == ev_cyc[ch]) begin
        if (ev_good[ch]) begin
          xv[ch] = 1;
          m_data[ch] = ev_byte[ch];
        end else xe[ch] = 1;
      end
    for (int ch = 1; ch >= 0; ch--)
      if (xv[ch]) begin
        m_rec = m_data[ch];
        m_ch  = ch[0];
      end
    chk("rx_valid", rx_valid, xv);
    chk("rx_err", rx_err, xe);
    chk("rx_data", rx_data, {m_data[1], m_data[0]});
    chk("most_recent", most_recent, m_rec);
    chk("most_recent_ch", most_recent_ch, m_ch);
    chk("dbg_out", dbg_out, xd);
    chk("ps2_clk_oe", oe, rst_s ? 2'b00 : inh_s);
    for (int ch = 0; ch < 2; ch++) begin
      vcnt[ch] += rx_valid[ch];
      ecnt[ch] += rx_err[ch];
    end
  end

  initial begin
    wait_cyc(3);
    rst = 0;
    wait_cyc(5);
    chk("lit_reset_data", rx_data, 16'h0000);
    chk("lit_reset_recent", most_recent, 8'h00);
    dbg_sel = 0;
    dbg_hi  = 1;
    send(2'b01, frame(8'h1C, 0), 11'h7FF, 11, 0);
    chk("lit_1c_data", rx_data[7:0], 8'h1C);
    chk("lit_1c_recent", most_recent, 8'h1C);
    chk("lit_1c_ch", most_recent_ch, 1'b0);
    chk("lit_1c_dbg", dbg_out, 4'h1);
    dbg_sel = 1;
    dbg_hi  = 0;
    send(2'b10, 11'h7FF, frame(8'h33, 0), 11, 0);
    chk("lit_33_data", rx_data[15:8], 8'h33);
    chk("lit_33_dbg", dbg_out, 4'h3);
    send(2'b10, 11'h7FF, frame(8'h1C, 1), 11, 0);
    chk("lit_badpar_keep", rx_data[15:8], 8'h33);
    send(2'b10, 11'h7FF, 11'h7FF, 1, 0);
    send(2'b01, frame(8'hF0, 0), 11'h7FF, 5, 1);
    wait_cyc(T + 20);
    chk("lit_timeout_errs", ecnt[0], 1);
    send(2'b01, frame(8'hF0, 0), 11'h7FF, 11, 0);
    chk("lit_f0_data", rx_data[7:0], 8'hF0);
    dbg_hi = 1;
    send(2'b11, frame(8'hF0, 0), frame(8'h08, 0), 11, 0);
    chk("lit_pair_data", rx_data, 16'h08F0);
    chk("lit_pair_recent", most_recent, 8'hF0);
    chk("lit_pair_ch", most_recent_ch, 1'b0);
    chk("lit_pair_dbg", dbg_out, 4'h0);
    send(2'b10, 11'h7FF, frame(8'h55, 0), 5, 2);
    inhibit[1] = 1;
    wait_cyc(1);
    chk("lit_inhibit_oe", oe, 2'b10);
    wait_cyc(T + 20);
    inhibit[1] = 0;
    wait_cyc(5);
    send(2'b10, 11'h7FF, frame(8'h55, 0), 11, 0);
    chk("lit_55_data", rx_data[15:8], 8'h55);
    chk("lit_55_recent", most_recent, 8'h55);
    chk("lit_55_ch", most_recent_ch, 1'b1);
    send(2'b01, frame(8'hAA, 0), 11'h7FF, 5, 2);
    rst = 1;
    wait_cyc(1);
    rst = 0;
    chk("lit_rst_data", rx_data, 16'h0000);
    chk("lit_rst_recent", most_recent, 8'h00);
    wait_cyc(5);
    send(2'b01, frame(8'hAA, 0), 11'h7FF, 11, 0);
    chk("lit_aa_data", rx_data, 16'h00AA);
    chk("lit_aa_recent", most_recent, 8'hAA);
    wait_cyc(T + 20);
    chk("lit_valid_cnt0", vcnt[0], 4);
    chk("lit_valid_cnt1", vcnt[1], 3);
    chk("lit_err_cnt0", ecnt[0], 1);
    chk("lit_err_cnt1", ecnt[1], 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
